filter_read_controller: RTL
===========================

# filter_read_controller

Sequencer for the filter-scratchpad read-address generator. It latches a job descriptor (filter size, filter count, window count) and drives the generator's `put_filter`, `next_filter` and `end_of_filter` strobes. It consumes the generator's `co_filter`, gates every read on a valid/ready handshake with the processing element (PE), and reports `busy` and `done` to the top-level convolution controller.

## Interface

Parameters:
- `FILTER_SIZE_REG_SIZE`, 8: width of the filter-size field; matches the address generator.
- `FILTER_COUNT_SIZE`, 4: width of the filter-count field and of `filter_index`.
- `WINDOW_COUNT_SIZE`, 8: width of the window-count field and of `window_index`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: job start; sampled only in IDLE.
- `filter_size`  in  FILTER_SIZE_REG_SIZE: elements per filter; latched on an accepted `start`.
- `num_filters`  in  FILTER_COUNT_SIZE: filters per window; latched on an accepted `start`.
- `num_windows`  in  WINDOW_COUNT_SIZE: windows per job; latched on an accepted `start`.
- `filter_ready`  in  1: filter scratchpad holds valid data.
- `pe_ready`  in  1: PE accepts an element this cycle.
- `co_filter`  in  1: generator carry-out; the current element is the last one of the filter.
- `filter_size_out`  out  FILTER_SIZE_REG_SIZE: latched filter size; feeds the generator.
- `put_filter`  out  1: element consumed; advances the generator's point in the filter.
- `next_filter`  out  1: advances the generator offset.
- `end_of_filter`  out  1: qualifies `next_filter` to wrap the generator offset to 0.
- `read_valid`  out  1: the read pointer addresses valid data for the PE.
- `filter_index`  out  FILTER_COUNT_SIZE: current filter within the window.
- `window_index`  out  WINDOW_COUNT_SIZE: current window.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.

## Operation

- States: IDLE, READ, NEXT, DONE.
- **IDLE**
  - On `start`, latch the three config fields and clear `filter_index` and `window_index`.
  - If any latched field is 0, go to DONE; otherwise go to READ.
  - `start` is ignored in every other state.
- **READ**
  - `read_valid = filter_ready`.
  - `put_filter = filter_ready & pe_ready`. This is the handshake; only a handshake counts as a transfer.
  - On a handshake with `co_filter = 1`, go to NEXT; otherwise stay in READ.
- **NEXT** (exactly one cycle)
  - `next_filter = 1`.
  - `end_of_filter = (filter_index == num_filters-1)`.
  - Not last filter: `filter_index++`, go to READ.
  - Last filter: `filter_index <= 0`.
    - Last window (`window_index == num_windows-1`): go to DONE.
    - Otherwise: `window_index++`, go to READ.
- **DONE**: `done = 1` for one cycle, then go to IDLE. Indices hold their final values until the next accepted `start`.
- `put_filter`, `next_filter` and `end_of_filter` are zero outside the states listed above.
- Comparisons are exact-width and unsigned; counters never exceed the latched count minus 1.
- `filter_size_out` holds its latched value from `start` until the next accepted `start`, so the generator's `co_filter` stays stable throughout the job.

## Timing

- Reset values:
  - State IDLE.
  - All outputs 0, including `filter_size_out`, both indices, `busy` and `done`.
  - Latched config 0.
- Latency:
  - `start` in cycle T gives READ in cycle T+1; the first `put_filter` is possible in T+1.
  - A job with no stalls takes 1 + num_windows·num_filters·(filter_size+1) + 1 cycles from `start` to `done`. The `done` cycle is included.
- `put_filter` and `next_filter` are never high in the same cycle.
- A stall (`pe_ready=0` or `filter_ready=0`) holds all state; `read_valid` may be high during a stall.
- `filter_size = 1`: every handshake carries `co_filter`, so the controller alternates READ and NEXT.
- `rst` mid-job: the next cycle is IDLE with all outputs 0. The generator shares `rst`, so both blocks restart consistently.
- `rst` and `start` in the same cycle: `rst` wins and the start is lost.

## Configuration

- Macro: `FILTER_READ_CTRL_STALL_COUNT_EN`.
- Defined:
  - Adds output `stall_cycles`, 16 bits.
  - It counts READ cycles with `put_filter = 0`.
  - It clears on an accepted `start` and on `rst`, and saturates at 0xFFFF.
  - It holds its value after `done`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan

- **Nominal:** filter_size=3, num_filters=2, num_windows=2, `pe_ready`/`filter_ready` tied high, generator model attached.
  - `start` to `done` in 18 cycles.
  - `put_filter` count 12, `next_filter` count 4.
  - `end_of_filter` high on the 2nd and 4th `next_filter`.
- **Backpressure:** same config, `pe_ready` low on every third READ cycle.
  - No dropped or duplicated `put_filter`.
  - Generator read pointers follow 0,1,2,3,4,5 per window.
  - With the macro defined, `stall_cycles` equals the number of low cycles.
- **Edge sizes:** filter_size=1, num_filters=1, num_windows=3.
  - READ and NEXT alternate.
  - `end_of_filter` accompanies all 3 `next_filter` pulses.
  - `done` 8 cycles after `start`.
- **Zero config:** num_filters=0.
  - `busy` for 1 cycle, then `done`.
  - No `put_filter` or `next_filter`.
- **Reset mid-job:** assert `rst` during window 1, filter 1.
  - Next cycle: all outputs 0, state IDLE.
  - A new `start` completes normally with the nominal counts.
- **Start while busy:** pulse `start` with different config mid-job.
  - Ignored; `filter_size_out` and the indices are unchanged; `done` timing is unaffected.

Source files
------------

// File: rtl/filter_read_controller.sv
// Filter-scratchpad read sequencer: walks windows x filters x elements.
// Optional stall counter: FILTER_READ_CTRL_STALL_COUNT_EN.
module filter_read_controller #(
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int FILTER_COUNT_SIZE    = 4,
  parameter int WINDOW_COUNT_SIZE    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  input  logic [FILTER_COUNT_SIZE-1:0]    num_filters,
  input  logic [WINDOW_COUNT_SIZE-1:0]    num_windows,
  input  logic                            filter_ready,
  input  logic                            pe_ready,
  input  logic                            co_filter,
  output logic [FILTER_SIZE_REG_SIZE-1:0] filter_size_out,
  output logic                            put_filter,
  output logic                            next_filter,
  output logic                            end_of_filter,
  output logic                            read_valid,
  output logic [FILTER_COUNT_SIZE-1:0]    filter_index,
  output logic [WINDOW_COUNT_SIZE-1:0]    window_index,
  output logic                            busy,
`ifdef FILTER_READ_CTRL_STALL_COUNT_EN
  output logic                            done,
  output logic [15:0]                     stall_cycles
`else
  output logic                            done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                          r_state;
  logic [FILTER_SIZE_REG_SIZE-1:0] r_fsize;
  logic [FILTER_COUNT_SIZE-1:0]    r_nfilt;
  logic [WINDOW_COUNT_SIZE-1:0]    r_nwin;
  logic [FILTER_COUNT_SIZE-1:0]    r_fidx;
  logic [WINDOW_COUNT_SIZE-1:0]    r_widx;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_next;
  logic                            r_eof;

  logic w_read;
  logic w_hs;
  logic w_last_f;
  logic w_last_w;
  logic w_zero;

  assign w_read   = (r_state == S_READ);
  assign w_hs     = w_read & filter_ready & pe_ready;
  assign w_last_f = (r_fidx == r_nfilt - FILTER_COUNT_SIZE'(1));
  assign w_last_w = (r_widx == r_nwin - WINDOW_COUNT_SIZE'(1));
  assign w_zero   = (filter_size == '0) | (num_filters == '0)
                  | (num_windows == '0);

  assign read_valid      = w_read & filter_ready;
  assign put_filter      = w_hs;
  assign next_filter     = r_next;
  assign end_of_filter   = r_eof;
  assign filter_size_out = r_fsize;
  assign filter_index    = r_fidx;
  assign window_index    = r_widx;
  assign busy            = r_busy;
  assign done            = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fsize <= '0;
      r_nfilt <= '0;
      r_nwin  <= '0;
      r_fidx  <= '0;
      r_widx  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_next  <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_next <= 1'b0;
      r_eof  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fsize <= filter_size;
            r_nfilt <= num_filters;
            r_nwin  <= num_windows;
            r_fidx  <= '0;
            r_widx  <= '0;
            r_busy  <= 1'b1;
            if (w_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (w_hs && co_filter) begin
            r_state <= S_NEXT;
            r_next  <= 1'b1;
            r_eof   <= w_last_f;
          end
        end
        S_NEXT: begin
          if (!w_last_f) begin
            r_fidx  <= r_fidx + FILTER_COUNT_SIZE'(1);
            r_state <= S_READ;
          end else begin
            r_fidx <= '0;
            if (w_last_w) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_widx  <= r_widx + WINDOW_COUNT_SIZE'(1);
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FILTER_READ_CTRL_STALL_COUNT_EN
  logic [15:0] r_stall;

  assign stall_cycles = r_stall;

  // Saturating count of READ cycles without a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_stall <= '0;
    end else if (w_read && !w_hs && r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end
`endif

endmodule
